// File: rtl/alu_writeback_ctrl.sv
// rtl/alu_writeback_ctrl.sv - multi-cycle execute/write-back controller in front of an 8x8 register file
module alu_writeback_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    output logic [ADDR_W-1:0] read_addr_1,
    output logic [ADDR_W-1:0] read_addr_2,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              RegWrite,
    output logic              zero_flag,
    output logic              carry_flag,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LI   = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [ADDR_W-1:0]   ra1_q, ra2_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [DATA_W-1:0]   res_q;
    logic                zero_q, carry_q;

    logic                accept;
    logic [DATA_W:0]     alu_ext;

    // Ready is suppressed while reset is held so nothing can be accepted during reset.
    assign instr_ready = (state_q == S_IDLE) & ~reset;
    assign accept      = instr_valid & instr_ready;
    assign busy        = (state_q != S_IDLE);
    assign RegWrite    = (state_q == S_WB);
    assign write_addr  = rd_q;
    assign write_data  = res_q;
    assign read_addr_1 = ra1_q;
    assign read_addr_2 = ra2_q;
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> READ -> EXEC -> WB -> IDLE, NOP skips WB.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = (op_q == OP_NOP) ? S_IDLE : S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU: one extra bit holds carry-out for adds and borrow for subtract.
    always_comb begin
        alu_ext = '0;
        case (op_q)
            OP_ADD:  alu_ext = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB:  alu_ext = {1'b0, a_q} - {1'b0, b_q};
            OP_AND:  alu_ext = {1'b0, a_q & b_q};
            OP_OR:   alu_ext = {1'b0, a_q | b_q};
            OP_XOR:  alu_ext = {1'b0, a_q ^ b_q};
            OP_LI:   alu_ext = {1'b0, imm_q};
            OP_ADDI: alu_ext = {1'b0, a_q} + {1'b0, imm_q};
            default: alu_ext = '0;
        endcase
    end

    // Datapath: latch fields at accept, operands in READ, result and flags in EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= OP_NOP;
            rd_q    <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= opcode;
                rd_q  <= rd;
                ra1_q <= rs1;
                ra2_q <= rs2;
                imm_q <= imm;
            end
            if (state_q == S_READ) begin
                a_q <= read_data_1;
                b_q <= read_data_2;
            end
            if ((state_q == S_EXEC) && (op_q != OP_NOP)) begin
                res_q   <= alu_ext[DATA_W-1:0];
                zero_q  <= (alu_ext[DATA_W-1:0] == '0);
                carry_q <= alu_ext[DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_alu_writeback_ctrl.sv
// tb/tb_alu_writeback_ctrl.sv - self-checking bench for alu_writeback_ctrl with a register file model
module tb_alu_writeback_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [2:0]    opcode = 3'd0;
    logic [AW-1:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [DW-1:0] imm = '0;
    logic [AW-1:0] read_addr_1, read_addr_2, write_addr;
    logic [DW-1:0] read_data_1, read_data_2, write_data;
    logic          RegWrite, zero_flag, carry_flag, busy;

    logic [DW-1:0] rf [8] = '{default: '0};

    int exp_rf [8] = '{default: 0};
    int exp_z = 0;
    int exp_c = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_writeback_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .write_addr(write_addr), .write_data(write_data), .RegWrite(RegWrite),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .busy(busy)
    );

    assign read_data_1 = rf[read_addr_1];
    assign read_data_2 = rf[read_addr_2];

    always @(posedge clk) begin
        if (RegWrite) rf[write_addr] <= write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue one instruction; the expected outcome comes from plain arithmetic on the model registers.
    task automatic issue(input int op, input int r_d, input int r_s1, input int r_s2,
                         input int im, input bit keep);
        int a, b, res, c, cnt, len;
        opcode = 3'(op); rd = AW'(r_d); rs1 = AW'(r_s1); rs2 = AW'(r_s2); imm = DW'(im);
        instr_valid = 1'b1;
        cnt = 0;
        while (instr_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("accept_timeout", 32'(cnt < 20), 32'd1);
        a = exp_rf[r_s1];
        b = exp_rf[r_s2];
        res = 0; c = 0;
        case (op)
            0: begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = im;
            6: begin res = (a + im) % 256; c = (a + im > 255) ? 1 : 0; end
            default: ;
        endcase
        @(posedge clk);
        #1;
        if (!keep) begin
            instr_valid = 1'b0;
            opcode = 3'($urandom); rd = AW'($urandom); rs1 = AW'($urandom);
            rs2 = AW'($urandom); imm = DW'($urandom);
        end
        len = (op == 7) ? 3 : 4;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("read_addr_1", 32'(read_addr_1), 32'(r_s1));
                chk("read_addr_2", 32'(read_addr_2), 32'(r_s2));
                chk("ready_in_read", 32'(instr_ready), 32'd0);
            end
            if (k < len) chk("busy_mid", 32'(busy), 32'd1);
            if (k == 3 && op != 7) begin
                chk("regwrite_wb", 32'(RegWrite), 32'd1);
                chk("write_addr", 32'(write_addr), 32'(r_d));
                chk("write_data", 32'(write_data), 32'(res));
                chk("zero_wb", 32'(zero_flag), 32'(res == 0));
                chk("carry_wb", 32'(carry_flag), 32'(c));
            end else begin
                chk("regwrite_off", 32'(RegWrite), 32'd0);
            end
            if (k == len) begin
                chk("ready_back", 32'(instr_ready), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
            end
        end
        if (op != 7) begin
            exp_rf[r_d] = res;
            exp_z = (res == 0) ? 1 : 0;
            exp_c = c;
        end
        chk("zero_flag", 32'(zero_flag), 32'(exp_z));
        chk("carry_flag", 32'(carry_flag), 32'(exp_c));
        chk("rf_dest", 32'(rf[r_d]), 32'(exp_rf[r_d]));
        chk("read_addr_hold", 32'(read_addr_1), 32'(r_s1));
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_waddr", 32'(write_addr), 32'd0);
        chk("rst_wdata", 32'(write_data), 32'd0);
        chk("rst_raddr1", 32'(read_addr_1), 32'd0);
        chk("rst_raddr2", 32'(read_addr_2), 32'd0);
        chk("rst_zero", 32'(zero_flag), 32'd0);
        chk("rst_carry", 32'(carry_flag), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(instr_ready), 32'd1);

        // Directed program
        issue(5, 1, 0, 0, 8'h07, 1'b0);
        issue(5, 2, 0, 0, 8'h08, 1'b0);
        chk("r1_li", 32'(rf[1]), 32'h07);
        chk("r2_li", 32'(rf[2]), 32'h08);
        chk("zero_after_li", 32'(zero_flag), 32'd0);
        issue(0, 3, 1, 2, 0, 1'b0);
        chk("r3_add", 32'(rf[3]), 32'h0F);
        chk("carry_add", 32'(carry_flag), 32'd0);
        issue(5, 4, 0, 0, 8'hFF, 1'b0);
        issue(6, 5, 4, 0, 8'h01, 1'b0);
        chk("r5_addi", 32'(rf[5]), 32'h00);
        chk("zero_addi", 32'(zero_flag), 32'd1);
        chk("carry_addi", 32'(carry_flag), 32'd1);
        issue(1, 6, 1, 2, 0, 1'b0);
        chk("r6_sub", 32'(rf[6]), 32'hFF);
        chk("borrow_sub", 32'(carry_flag), 32'd1);
        chk("zero_sub", 32'(zero_flag), 32'd0);
        issue(4, 7, 1, 1, 0, 1'b0);
        chk("r7_xor", 32'(rf[7]), 32'h00);
        chk("zero_xor", 32'(zero_flag), 32'd1);
        chk("carry_xor", 32'(carry_flag), 32'd0);

        // NOP with valid held through READ and EXEC: accepted once
        issue(7, 2, 3, 4, 0, 1'b1);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("nop_no_reaccept", 32'(busy), 32'd0);
        chk("nop_no_write", 32'(RegWrite), 32'd0);
        chk("nop_r2_kept", 32'(rf[2]), 32'h08);

        // Back-to-back with valid held high: second read sees first write
        issue(0, 1, 1, 1, 0, 1'b1);
        chk("r1_b2b_first", 32'(rf[1]), 32'h0E);
        issue(0, 1, 1, 1, 0, 1'b0);
        chk("r1_b2b_second", 32'(rf[1]), 32'h1C);

        // Reset during WB of LI r3,0x55
        opcode = 3'd5; rd = 3'd3; imm = 8'h55; instr_valid = 1'b1;
        chk("wbrst_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wbrst_in_wb", 32'(RegWrite), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("wbrst_regwrite", 32'(RegWrite), 32'd0);
        chk("wbrst_waddr", 32'(write_addr), 32'd0);
        chk("wbrst_wdata", 32'(write_data), 32'd0);
        chk("wbrst_raddr1", 32'(read_addr_1), 32'd0);
        chk("wbrst_busy", 32'(busy), 32'd0);
        chk("wbrst_ready_low", 32'(instr_ready), 32'd0);
        chk("wbrst_flags", 32'({zero_flag, carry_flag}), 32'd0);
        exp_z = 0;
        exp_c = 0;
        @(negedge clk);
        chk("wbrst_r3_kept", 32'(rf[3]), 32'(exp_rf[3]));
        reset = 1'b0;
        @(negedge clk);
        chk("wbrst_ready_after", 32'(instr_ready), 32'd1);
        chk("wbrst_r3_still", 32'(rf[3]), 32'h0F);

        // Randomized instructions against the model
        for (int i = 0; i < 40; i++) begin
            int gap;
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 255)), 1'b0);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end
        for (int r = 0; r < 8; r++) chk("final_rf", 32'(rf[r]), 32'(exp_rf[r]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
